imem_boot_loader: RTL and testbench

Boot sequencer for the single-cycle RV32I core's instruction memory. It holds the CPU in reset, receives a program image as a byte stream, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory write port starting at byte address 0. After the last word is written it releases the CPU. It sits between the byte-stream source (UART receiver or testbench) and the instruction memory/CPU reset.

---
 rtl/imem_boot_loader.sv | 193 +++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot sequencer for the RV32I instruction memory. It holds the CPU in
//   reset and receives a byte stream made of a 16-bit word count N (low byte
//   first) followed by N little-endian 32-bit words. Each word is written to
//   the instruction memory at byte address word_idx*4, starting from 0. When
//   the load completes, the CPU is released.
//
//   Optional feature: define IMEM_BOOT_CHECKSUM_EN to expect one trailing
//   byte. That byte is the XOR of all payload bytes. A mismatch aborts to ERR.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             load request pulse (honoured in IDLE/DONE/ERR)
//   rx_data/valid     byte stream in; rx_ready is the registered accept flag
//   mem_we/waddr/wdata instruction memory write port (one cycle per word)
//   cpu_hold          high keeps the CPU in reset
//   done / error      load finished successfully / aborted
//   loaded_words      words written in the current or last load
//
// State table
//   IDLE   | after reset, waiting for start, CPU held
//   LEN_LO | accepting low byte of word count
//   LEN_HI | accepting high byte of word count, range check
//   DATA   | accepting payload bytes, writing one word per four bytes
//   LAST   | one quiet cycle so the final write lands before release
//   CHK    | accepting checksum byte (IMEM_BOOT_CHECKSUM_EN only)
//   DONE   | load complete, CPU released
//   ERR    | load aborted, CPU held until start or reset
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [31:0]       mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   loaded_words
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_LAST,
`ifdef IMEM_BOOT_CHECKSUM_EN
    ST_CHK,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [16:0]     CAP    = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] LW_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [7:0]        len_lo;
  logic [ADDR_W:0]   n_words;
  logic [1:0]        lane;
  logic [23:0]       word_buf;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic              xfer;
  logic [15:0]       len_full;
  logic              len_bad;
  logic [ADDR_W:0]   words_next;

  assign xfer       = rx_valid & rx_ready;
  assign len_full   = {rx_data, len_lo};
  assign len_bad    = (len_full == 16'd0) || ({1'b0, len_full} > CAP);
  assign words_next = loaded_words + LW_ONE;

  // loaded_words doubles as the word index: both restart at 0 for every load
  // and advance together on each written word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      rx_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= 32'd0;
      mem_wdata    <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      loaded_words <= '0;
      len_lo       <= 8'd0;
      n_words      <= '0;
      lane         <= 2'd0;
      word_buf     <= 24'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_LEN_LO;
            rx_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum     <= 8'd0;
`endif
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            len_lo <= rx_data;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            if (len_bad) begin
              state    <= ST_ERR;
              rx_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state        <= ST_DATA;
              n_words      <= len_full[ADDR_W:0];
              loaded_words <= '0;
              lane         <= 2'd0;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                mem_wdata    <= {rx_data, word_buf};
                mem_waddr    <= {{(30-ADDR_W){1'b0}}, loaded_words[ADDR_W-1:0], 2'b00};
                mem_we       <= 1'b1;
                loaded_words <= words_next;
                if (words_next == n_words) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                  state    <= ST_CHK;
`else
                  state    <= ST_LAST;
                  rx_ready <= 1'b0;
`endif
                end
              end
            endcase
          end
        end
        ST_LAST: begin
          state    <= ST_DONE;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        ST_CHK: begin
          if (xfer) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          rx_ready <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//   Scoreboard bench for imem_boot_loader (ADDR_W = 8). Expected memory
//   writes are queued as stream bytes are driven and compared on each
//   mem_we pulse. Honours IMEM_BOOT_CHECKSUM_EN like the design.
module tb_imem_boot_loader;

  localparam int ADDR_W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic            mem_we;
  logic [31:0]     mem_waddr;
  logic [31:0]     mem_wdata;
  logic            cpu_hold;
  logic            done;
  logic            error;
  logic [ADDR_W:0] loaded_words;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_waddr = 32'hFFFF_FFFF;
  logic [31:0] fix_words [2] = '{32'h00208233, 32'h402082B3};

  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .loaded_words(loaded_words)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_we", mem_waddr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk_eq("waddr", mem_waddr, e[63:32]);
        chk_eq("wdata", mem_wdata, e[31:0]);
        last_waddr = mem_waddr;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Present one byte (after an optional random gap) and hold it until taken.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int n;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) cycle();
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 64) begin
      cycle();
      n++;
    end
    if (!rx_ready) begin
      chk_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    cycle();
    rx_valid = 1'b0;
  endtask

  // Drive a full load. nw = 0 means the length must be rejected.
  // stop_after > 0 abandons the stream after that many payload bytes.
  task automatic run_stream(input logic [15:0] len, input int nw, input bit fixed,
                            input int gap_pct, input bit mid_start, input bit bad_ck,
                            input int stop_after);
    logic [7:0]  ck;
    logic [31:0] word;
    int          sent;
    ck   = 8'd0;
    sent = 0;
    pulse_start();
    chk_eq("start_ready", 32'(rx_ready), 32'd1);
    chk_eq("start_hold", 32'(cpu_hold), 32'd1);
    chk_eq("start_done_clr", 32'(done), 32'd0);
    chk_eq("start_err_clr", 32'(error), 32'd0);
    send_byte(len[7:0], 0);
    send_byte(len[15:8], 0);
    if (nw == 0) begin
      chk_eq("len_err", 32'(error), 32'd1);
      chk_eq("len_err_hold", 32'(cpu_hold), 32'd1);
      chk_eq("len_err_ready", 32'(rx_ready), 32'd0);
      return;
    end
    for (int w = 0; w < nw; w++) begin
      word = fixed ? fix_words[w] : $urandom;
      exp_q.push_back({32'(w * 4), word});
      for (int l = 0; l < 4; l++) begin
        ck = ck ^ word[8*l +: 8];
        if (mid_start && w == 0 && l == 1) start = 1'b1;
        send_byte(word[8*l +: 8], gap_pct);
        start = 1'b0;
        sent++;
        if (sent == stop_after) begin
          if (l != 3) void'(exp_q.pop_back());
          return;
        end
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_byte(bad_ck ? (ck ^ 8'h01) : ck, 0);
    if (bad_ck) begin
      chk_eq("ck_bad_err", 32'(error), 32'd1);
      chk_eq("ck_bad_hold", 32'(cpu_hold), 32'd1);
      chk_eq("ck_bad_done", 32'(done), 32'd0);
    end else begin
      chk_eq("ck_ok_done", 32'(done), 32'd1);
      chk_eq("ck_ok_hold", 32'(cpu_hold), 32'd0);
      chk_eq("ck_ok_err", 32'(error), 32'd0);
    end
`else
    if (bad_ck) chk_eq("bad_ck_unsupported", 32'd1, 32'd0);
    chk_eq("last_done", 32'(done), 32'd0);
    chk_eq("last_ready", 32'(rx_ready), 32'd0);
    cycle();
    chk_eq("rel_done", 32'(done), 32'd1);
    chk_eq("rel_hold", 32'(cpu_hold), 32'd0);
    chk_eq("rel_err", 32'(error), 32'd0);
`endif
    chk_eq("loaded_words", 32'(loaded_words), 32'(nw));
    chk_eq("post_ready", 32'(rx_ready), 32'd0);
    cycle();
    chk_eq("writes_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    cycle();
    cycle();
    chk_eq("rst_hold", 32'(cpu_hold), 32'd1);
    chk_eq("rst_ready", 32'(rx_ready), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_err", 32'(error), 32'd0);
    chk_eq("rst_we", 32'(mem_we), 32'd0);
    chk_eq("rst_waddr", mem_waddr, 32'd0);
    chk_eq("rst_wdata", mem_wdata, 32'd0);
    chk_eq("rst_words", 32'(loaded_words), 32'd0);
    reset = 1'b0;

    // Bytes offered in IDLE must not be taken.
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    repeat (4) cycle();
    chk_eq("idle_ready", 32'(rx_ready), 32'd0);
    chk_eq("idle_hold", 32'(cpu_hold), 32'd1);
    rx_valid = 1'b0;

    // Two-word program, back-to-back.
    run_stream(16'd2, 2, 1'b1, 0, 1'b0, 1'b0, 0);
`ifdef IMEM_BOOT_CHECKSUM_EN
    // Same stream with a wrong trailer: writes still happen, then ERR.
    run_stream(16'd2, 2, 1'b1, 0, 1'b0, 1'b1, 0);
`endif

    // Length errors: zero and one beyond capacity.
    run_stream(16'h0000, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    run_stream(16'h0101, 0, 1'b0, 0, 1'b0, 1'b0, 0);

    // Gaps on rx_valid plus a start pulse mid-DATA that must be ignored.
    run_stream(16'd2, 2, 1'b1, 40, 1'b1, 1'b0, 0);
    run_stream(16'd6, 6, 1'b0, 30, 1'b0, 1'b0, 0);

    // Full capacity: last write lands at 0x3FC.
    run_stream(16'h0100, 256, 1'b0, 0, 1'b0, 1'b0, 0);
    chk_eq("cap_last_addr", last_waddr, 32'h0000_03FC);

    // Reset after five payload bytes, then a clean reload from address 0.
    run_stream(16'd2, 2, 1'b1, 0, 1'b0, 1'b0, 5);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk_eq("midrst_hold", 32'(cpu_hold), 32'd1);
    chk_eq("midrst_ready", 32'(rx_ready), 32'd0);
    chk_eq("midrst_done", 32'(done), 32'd0);
    chk_eq("midrst_writes_left", 32'(exp_q.size()), 32'd0);
    run_stream(16'd2, 2, 1'b1, 0, 1'b0, 1'b0, 0);

    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
